// File: rtl/vga_pkg.sv
// SVGA 800x600@60 timing constants shared by the raster generator and its consumers.
package vga_pkg;

    localparam int CNT_W = 11;
    localparam int RGB_W = 12;

    localparam logic [CNT_W-1:0] HOR_TOTAL_TIME  = 11'd1056;
    localparam logic [CNT_W-1:0] HOR_BLANK_START = 11'd800;
    localparam logic [CNT_W-1:0] HOR_SYNC_START  = 11'd840;
    localparam logic [CNT_W-1:0] HOR_SYNC_TIME   = 11'd128;

    localparam logic [CNT_W-1:0] VER_TOTAL_TIME  = 11'd628;
    localparam logic [CNT_W-1:0] VER_BLANK_START = 11'd600;
    localparam logic [CNT_W-1:0] VER_SYNC_START  = 11'd601;
    localparam logic [CNT_W-1:0] VER_SYNC_TIME   = 11'd4;

    localparam logic [CNT_W-1:0] HOR_LAST = HOR_TOTAL_TIME - 11'd1;
    localparam logic [CNT_W-1:0] VER_LAST = VER_TOTAL_TIME - 11'd1;

endpackage

// File: rtl/vga_if.sv
// Raster timing bundle: counters, syncs, blanking and pixel colour travel together.
interface vga_if;
    import vga_pkg::*;

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_timing.sv
// SVGA 800x600@60 raster counter; flags decode the next counts so they register in step.
module vga_timing
    import vga_pkg::*;
(
    input  logic clk,
    input  logic rst,
    vga_if.out   out
);

    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;

    always_comb begin
        h_next = (out.hcount >= HOR_LAST) ? '0 : out.hcount + 11'd1;
        v_next = out.vcount;
        // an out-of-range vertical count recovers on the very next clock
        if (out.vcount > VER_LAST) begin
            v_next = '0;
        end else if (out.hcount == HOR_LAST) begin
            v_next = (out.vcount == VER_LAST) ? '0 : out.vcount + 11'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
        end else begin
            out.hcount <= h_next;
            out.vcount <= v_next;
            out.hblnk  <= (h_next >= HOR_BLANK_START);
            out.hsync  <= (h_next >= HOR_SYNC_START) &&
                          (h_next <  HOR_SYNC_START + HOR_SYNC_TIME);
            out.vblnk  <= (v_next >= VER_BLANK_START);
            out.vsync  <= (v_next >= VER_SYNC_START) &&
                          (v_next <  VER_SYNC_START + VER_SYNC_TIME);
        end
    end

    assign out.rgb = '0;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: reference counter model plus per-clock decode checks.
module tb_vga_timing;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   hm    = 0;
    int   vm    = 0;

    vga_if bus ();

    vga_timing dut (
        .clk (clk),
        .rst (rst),
        .out (bus.out)
    );

    always #12.5 clk = ~clk;

    task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] expect_vec(input int h, input int v);
        logic hs, vs, hb, vb;
        logic [10:0] hh, vv;
        hb = (h >= 800);
        hs = (h >= 840) && (h <= 967);
        vb = (v >= 600);
        vs = (v >= 601) && (v <= 604);
        hh = 11'(h);
        vv = 11'(v);
        return {hh, vv, hs, vs, hb, vb, 12'h000};
    endfunction

    function automatic logic [37:0] observed_vec();
        return {bus.hcount, bus.vcount, bus.hsync, bus.vsync, bus.hblnk, bus.vblnk, bus.rgb};
    endfunction

    // one clock: advance the reference counters and compare the whole bundle
    task automatic tick(input string tag);
        int nh, nv;
        @(posedge clk);
        #1;
        if (rst) begin
            hm = 0;
            vm = 0;
        end else begin
            nh = (hm >= 1055) ? 0 : hm + 1;
            nv = vm;
            if (vm > 627)       nv = 0;
            else if (hm == 1055) nv = (vm == 627) ? 0 : vm + 1;
            hm = nh;
            vm = nv;
        end
        check(tag, observed_vec(), expect_vec(hm, vm));
    endtask

    task automatic jump(input int h, input int v);
        @(negedge clk);
        force bus.hcount = 11'(h);
        force bus.vcount = 11'(v);
        #1;
        release bus.hcount;
        release bus.vcount;
        hm = h;
        vm = v;
    endtask

    initial begin
        int hb_cnt, hs_rise, hs_fall, vs_cnt, vs_rise_v, vs_rise_h, vs_fall_v;
        logic prev_hs, prev_vs, wrap_seen;
        int prev_v;

        repeat (10) tick("reset_hold");
        check("reset_hcount", 38'(bus.hcount), 38'(0));
        check("reset_flags", 38'({bus.hsync, bus.vsync, bus.hblnk, bus.vblnk}), 38'(0));
        rst = 1'b0;

        repeat (60) tick("run60");
        check("run60_hcount", 38'(bus.hcount), 38'(60));
        check("run60_vcount", 38'(bus.vcount), 38'(0));
        check("run60_hblnk", 38'(bus.hblnk), 38'(0));

        hb_cnt = 0; hs_rise = -1; hs_fall = -1; prev_hs = bus.hsync;
        repeat (995) begin
            tick("line0");
            if (bus.hblnk) hb_cnt++;
            if (bus.hsync && !prev_hs) hs_rise = int'(bus.hcount);
            if (!bus.hsync && prev_hs) hs_fall = int'(bus.hcount);
            prev_hs = bus.hsync;
        end
        check("line_end_hcount", 38'(bus.hcount), 38'(1055));
        check("hblnk_width", 38'(hb_cnt), 38'(256));
        check("hsync_rise", 38'(hs_rise), 38'(840));
        check("hsync_fall", 38'(hs_fall), 38'(968));
        check("hsync_width", 38'(hs_fall - hs_rise), 38'(128));
        tick("line_wrap");
        check("wrap_hcount", 38'(bus.hcount), 38'(0));
        check("wrap_vcount", 38'(bus.vcount), 38'(1));

        // skip ahead to the bottom of the frame and run through the vertical blank
        jump(1000, 598);
        vs_cnt = 0; vs_rise_v = -1; vs_rise_h = -1; vs_fall_v = -1;
        prev_vs = 1'b0; wrap_seen = 1'b0; prev_v = 598;
        repeat (30680) begin
            tick("frame_tail");
            if (bus.vsync) vs_cnt++;
            if (bus.vsync && !prev_vs) begin
                vs_rise_v = int'(bus.vcount);
                vs_rise_h = int'(bus.hcount);
            end
            if (!bus.vsync && prev_vs) vs_fall_v = int'(bus.vcount);
            if (prev_v == 627 && bus.vcount == 11'd0) wrap_seen = 1'b1;
            prev_vs = bus.vsync;
            prev_v  = int'(bus.vcount);
        end
        check("vsync_clocks", 38'(vs_cnt), 38'(4224));
        check("vsync_rise_line", 38'(vs_rise_v), 38'(601));
        check("vsync_rise_pixel", 38'(vs_rise_h), 38'(0));
        check("vsync_fall_line", 38'(vs_fall_v), 38'(605));
        check("vcount_wrap_seen", 38'(wrap_seen), 38'(1));
        check("frame_wrap_pos", 38'({bus.hcount, bus.vcount}), 38'(0));

        jump(499, 300);
        tick("pre_midrst");
        check("midrst_pos", 38'({bus.hcount, bus.vcount}), 38'({11'd500, 11'd300}));
        rst = 1'b1;
        tick("midrst");
        check("midrst_zero", observed_vec(), 38'(0));
        rst = 1'b0;
        repeat (5) tick("resume");
        check("resume_hcount", 38'(bus.hcount), 38'(5));

        jump(100, 700);
        tick("bad_vcount");
        check("bad_vcount_recover", 38'({bus.hcount, bus.vcount}), 38'({11'd101, 11'd0}));
        jump(2000, 5);
        tick("bad_hcount");
        check("bad_hcount_recover", 38'({bus.hcount, bus.vcount}), 38'({11'd0, 11'd5}));
        repeat (20) tick("post_recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
